// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and stall/flush control.
// Optional hazard-stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int XLEN         = 32,
  parameter int WIDTH_SOURCE = 5,
  parameter int ALU_CTRL_W   = 4
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [WIDTH_SOURCE-1:0] ID_src_1,
  input  logic [WIDTH_SOURCE-1:0] ID_src_2,
  input  logic [WIDTH_SOURCE-1:0] ID_Rd,
  input  logic                    ID_Reg_Wr,
  input  logic                    ID_Mem_Rd,
  input  logic                    ID_Mem_Wr,
  input  logic [ALU_CTRL_W-1:0]   ID_ALU_Ctrl,
  input  logic [XLEN-1:0]         ID_Rs1_Data,
  input  logic [XLEN-1:0]         ID_Rs2_Data,
  input  logic [XLEN-1:0]         ID_Imm,
  input  logic [XLEN-1:0]         ID_PC,
  input  logic                    EX_Flush,
  input  logic                    MEM_Busy,
  output logic [WIDTH_SOURCE-1:0] ID_EX_src_1,
  output logic [WIDTH_SOURCE-1:0] ID_EX_src_2,
  output logic [WIDTH_SOURCE-1:0] ID_EX_Rd,
  output logic                    ID_EX_Reg_Wr,
  output logic                    ID_EX_Mem_Rd,
  output logic                    ID_EX_Mem_Wr,
  output logic [ALU_CTRL_W-1:0]   ID_EX_ALU_Ctrl,
  output logic [XLEN-1:0]         ID_EX_Rs1_Data,
  output logic [XLEN-1:0]         ID_EX_Rs2_Data,
  output logic [XLEN-1:0]         ID_EX_Imm,
  output logic [XLEN-1:0]         ID_EX_PC,
  output logic                    ID_EX_Valid,
  output logic                    PC_Write,
  output logic                    IF_ID_Write
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]             ID_EX_Stall_Cnt
`endif
);

  typedef struct packed {
    logic                    valid;
    logic [WIDTH_SOURCE-1:0] src_1;
    logic [WIDTH_SOURCE-1:0] src_2;
    logic [WIDTH_SOURCE-1:0] rd;
    logic                    reg_wr;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [ALU_CTRL_W-1:0]   alu_ctrl;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         pc;
  } id_ex_t;

  id_ex_t stage_q, stage_d;

  logic hz;
  logic sel_busy, sel_flush, sel_hz;

  assign hz = stage_q.valid & stage_q.mem_rd
            & (stage_q.rd != '0)
            & ((stage_q.rd == ID_src_1)
             | (stage_q.rd == ID_src_2));

  // One-hot action selects encode the busy > flush > hazard priority.
  assign sel_busy  = MEM_Busy;
  assign sel_flush = ~MEM_Busy & EX_Flush;
  assign sel_hz    = ~MEM_Busy & ~EX_Flush & hz;

  always_comb begin
    stage_d     = stage_q;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    unique case (1'b1)
      sel_busy: begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
      end
      sel_flush: begin
        stage_d.valid  = 1'b0;
        stage_d.reg_wr = 1'b0;
        stage_d.mem_rd = 1'b0;
        stage_d.mem_wr = 1'b0;
        stage_d.rd     = '0;
        stage_d.src_1  = '0;
        stage_d.src_2  = '0;
      end
      sel_hz: begin
        PC_Write       = 1'b0;
        IF_ID_Write    = 1'b0;
        stage_d.valid  = 1'b0;
        stage_d.reg_wr = 1'b0;
        stage_d.mem_rd = 1'b0;
        stage_d.mem_wr = 1'b0;
        stage_d.rd     = '0;
        stage_d.src_1  = '0;
        stage_d.src_2  = '0;
      end
      default: begin
        stage_d.valid    = 1'b1;
        stage_d.src_1    = ID_src_1;
        stage_d.src_2    = ID_src_2;
        stage_d.rd       = ID_Rd;
        stage_d.reg_wr   = ID_Reg_Wr;
        stage_d.mem_rd   = ID_Mem_Rd;
        stage_d.mem_wr   = ID_Mem_Wr;
        stage_d.alu_ctrl = ID_ALU_Ctrl;
        stage_d.rs1_data = ID_Rs1_Data;
        stage_d.rs2_data = ID_Rs2_Data;
        stage_d.imm      = ID_Imm;
        stage_d.pc       = ID_PC;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign ID_EX_Valid    = stage_q.valid;
  assign ID_EX_src_1    = stage_q.src_1;
  assign ID_EX_src_2    = stage_q.src_2;
  assign ID_EX_Rd       = stage_q.rd;
  assign ID_EX_Reg_Wr   = stage_q.reg_wr;
  assign ID_EX_Mem_Rd   = stage_q.mem_rd;
  assign ID_EX_Mem_Wr   = stage_q.mem_wr;
  assign ID_EX_ALU_Ctrl = stage_q.alu_ctrl;
  assign ID_EX_Rs1_Data = stage_q.rs1_data;
  assign ID_EX_Rs2_Data = stage_q.rs2_data;
  assign ID_EX_Imm      = stage_q.imm;
  assign ID_EX_PC       = stage_q.pc;

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sel_hz && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ID_EX_Stall_Cnt = cnt_q;
`endif

endmodule
